// File: rtl/crc_16_pkg.sv
// -----------------------------------------------------------------------------
// crc_16_pkg
// Shared definitions for the CRC-16-CCITT generator/checker pair.
//   C_CRC16_POLY     generator polynomial x^16 + x^12 + x^5 + 1
//   crc_chk_state_t  checker frame FSM states
//   crc16_ccit_byte  one-byte CRC update, MSB first, no reflection, no final XOR
// -----------------------------------------------------------------------------
package crc_16_pkg;

    localparam logic [15:0] C_CRC16_POLY = 16'h1021;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RX   = 1'b1
    } crc_chk_state_t;

    // Folding the data byte into the top of the register first lets the
    // eight shift/XOR steps run without touching the data again.
    function automatic logic [15:0] crc16_ccit_byte(input logic [15:0] crc,
                                                     input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) begin
                c = {c[14:0], 1'b0} ^ C_CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_16_ccit_checker.sv
// -----------------------------------------------------------------------------
// crc_16_ccit_checker
// Receive-side CRC-16-CCITT check of a framed byte stream. The last two bytes
// of each frame carry the transmitted CRC (MSB first); the CRC is recomputed
// over the payload and a match/mismatch/length verdict is reported.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   i_val       i_data/i_sof/i_eof valid this cycle
//   i_sof       first byte of frame
//   i_eof       last byte of frame (CRC LSB)
//   i_data      frame byte
//   o_busy      frame in progress
//   o_done      one-cycle pulse: result outputs updated
//   o_crc_ok    received CRC equals computed CRC, length valid
//   o_crc_err   CRC mismatch, length valid
//   o_len_err   frame shorter than 3 bytes or byte counter overflow
//   o_crc_calc  CRC computed over the payload
//   o_crc_rcv   CRC taken from the last two bytes
//   o_len       payload length (total bytes - 2), 0 on length error
// -----------------------------------------------------------------------------
module crc_16_ccit_checker
    import crc_16_pkg::*;
#(
    parameter logic [15:0] G_CRC_INIT  = 16'hFFFF,
    parameter int          G_LEN_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_val,
    input  logic                   i_sof,
    input  logic                   i_eof,
    input  logic [7:0]             i_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_crc_ok,
    output logic                   o_crc_err,
    output logic                   o_len_err,
    output logic [15:0]            o_crc_calc,
    output logic [15:0]            o_crc_rcv,
    output logic [G_LEN_WIDTH-1:0] o_len
);

    localparam logic [G_LEN_WIDTH-1:0] C_CNT_ZERO = {G_LEN_WIDTH{1'b0}};
    localparam logic [G_LEN_WIDTH-1:0] C_CNT_ONE  = G_LEN_WIDTH'(1);
    localparam logic [G_LEN_WIDTH-1:0] C_CNT_TWO  = G_LEN_WIDTH'(2);
    localparam logic [G_LEN_WIDTH-1:0] C_CNT_MAX  = {G_LEN_WIDTH{1'b1}};

    // Frame state
    crc_chk_state_t         state_r;
    crc_chk_state_t         state_nxt_s;
    logic [15:0]            crc_r;
    logic [15:0]            crc_nxt_s;
    logic [G_LEN_WIDTH-1:0] cnt_r;
    logic [G_LEN_WIDTH-1:0] cnt_nxt_s;
    logic [7:0]             d0_r;
    logic [7:0]             d0_nxt_s;
    logic [7:0]             d1_r;
    logic [7:0]             d1_nxt_s;
    logic                   ovf_r;
    logic                   ovf_nxt_s;

    // Result registers
    logic                   busy_r;
    logic                   busy_nxt_s;
    logic                   done_r;
    logic                   done_nxt_s;
    logic                   ok_r;
    logic                   ok_nxt_s;
    logic                   err_r;
    logic                   err_nxt_s;
    logic                   len_err_r;
    logic                   len_err_nxt_s;
    logic [15:0]            calc_r;
    logic [15:0]            calc_nxt_s;
    logic [15:0]            rcv_r;
    logic [15:0]            rcv_nxt_s;
    logic [G_LEN_WIDTH-1:0] len_r;
    logic [G_LEN_WIDTH-1:0] len_nxt_s;

    // Decoded events
    logic                   sof_s;
    logic                   eof_sof_s;
    logic                   eof_rx_s;
    logic                   byte_rx_s;
    logic                   cnt_ge2_s;
    logic                   cnt_max_s;
    logic [15:0]            crc_step_s;
    logic [15:0]            crc_final_s;
    logic [15:0]            rcv_final_s;
    logic                   len_bad_s;

    // Event decode and the same-cycle CRC step over the older delay-line byte.
    // The delay line keeps the two most recent bytes out of the CRC so that
    // the trailing CRC field is never folded into the computation.
    always_comb begin
        sof_s       = i_val & i_sof;
        eof_sof_s   = i_val & i_sof & i_eof;
        eof_rx_s    = i_val & ~i_sof & i_eof & (state_r == S_RX);
        byte_rx_s   = i_val & ~i_sof & ~i_eof & (state_r == S_RX);
        cnt_ge2_s   = (cnt_r >= C_CNT_TWO);
        cnt_max_s   = (cnt_r == C_CNT_MAX);
        crc_step_s  = crc16_ccit_byte(crc_r, d1_r);
        crc_final_s = cnt_ge2_s ? crc_step_s : crc_r;
        rcv_final_s = {d0_r, i_data};
        // Total length including the eof byte is cnt_r + 1; a saturated
        // counter means that total no longer fits.
        len_bad_s   = (cnt_r < C_CNT_TWO) | ovf_r | cnt_max_s;
    end

    // FSM next state: sof always (re)starts a frame, eof always ends one.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (sof_s && !i_eof) begin
                    state_nxt_s = S_RX;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RX: begin
                if (i_val && i_eof) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RX;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Frame datapath next values: CRC register, byte counter, delay line.
    always_comb begin
        crc_nxt_s = crc_r;
        cnt_nxt_s = cnt_r;
        d0_nxt_s  = d0_r;
        d1_nxt_s  = d1_r;
        ovf_nxt_s = ovf_r;
        if (sof_s) begin
            // A sof mid-frame silently discards the frame in progress.
            crc_nxt_s = G_CRC_INIT;
            cnt_nxt_s = C_CNT_ONE;
            d0_nxt_s  = i_data;
            d1_nxt_s  = 8'h00;
            ovf_nxt_s = 1'b0;
        end else if (eof_rx_s) begin
            crc_nxt_s = G_CRC_INIT;
            cnt_nxt_s = C_CNT_ZERO;
            d0_nxt_s  = 8'h00;
            d1_nxt_s  = 8'h00;
            ovf_nxt_s = 1'b0;
        end else if (byte_rx_s) begin
            if (cnt_ge2_s) begin
                crc_nxt_s = crc_step_s;
            end else begin
                crc_nxt_s = crc_r;
            end
            d1_nxt_s = d0_r;
            d0_nxt_s = i_data;
            if (cnt_max_s) begin
                ovf_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + C_CNT_ONE;
            end
        end else begin
            crc_nxt_s = crc_r;
        end
    end

    // FSM outputs: result values captured at frame end, held otherwise.
    always_comb begin
        busy_nxt_s    = (state_nxt_s == S_RX);
        done_nxt_s    = 1'b0;
        ok_nxt_s      = ok_r;
        err_nxt_s     = err_r;
        len_err_nxt_s = len_err_r;
        calc_nxt_s    = calc_r;
        rcv_nxt_s     = rcv_r;
        len_nxt_s     = len_r;
        if (eof_sof_s) begin
            // Single-byte frame: nothing to check, always a length error.
            done_nxt_s    = 1'b1;
            ok_nxt_s      = 1'b0;
            err_nxt_s     = 1'b0;
            len_err_nxt_s = 1'b1;
            calc_nxt_s    = G_CRC_INIT;
            rcv_nxt_s     = {8'h00, i_data};
            len_nxt_s     = C_CNT_ZERO;
        end else if (eof_rx_s) begin
            done_nxt_s = 1'b1;
            calc_nxt_s = crc_final_s;
            rcv_nxt_s  = rcv_final_s;
            if (len_bad_s) begin
                ok_nxt_s      = 1'b0;
                err_nxt_s     = 1'b0;
                len_err_nxt_s = 1'b1;
                len_nxt_s     = C_CNT_ZERO;
            end else begin
                ok_nxt_s      = (crc_final_s == rcv_final_s);
                err_nxt_s     = (crc_final_s != rcv_final_s);
                len_err_nxt_s = 1'b0;
                len_nxt_s     = cnt_r - C_CNT_ONE;
            end
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // State register: FSM, frame datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            crc_r     <= G_CRC_INIT;
            cnt_r     <= C_CNT_ZERO;
            d0_r      <= 8'h00;
            d1_r      <= 8'h00;
            ovf_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ok_r      <= 1'b0;
            err_r     <= 1'b0;
            len_err_r <= 1'b0;
            calc_r    <= 16'h0000;
            rcv_r     <= 16'h0000;
            len_r     <= C_CNT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            crc_r     <= crc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            d0_r      <= d0_nxt_s;
            d1_r      <= d1_nxt_s;
            ovf_r     <= ovf_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            ok_r      <= ok_nxt_s;
            err_r     <= err_nxt_s;
            len_err_r <= len_err_nxt_s;
            calc_r    <= calc_nxt_s;
            rcv_r     <= rcv_nxt_s;
            len_r     <= len_nxt_s;
        end
    end

    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_crc_ok   = ok_r;
    assign o_crc_err  = err_r;
    assign o_len_err  = len_err_r;
    assign o_crc_calc = calc_r;
    assign o_crc_rcv  = rcv_r;
    assign o_len      = len_r;

endmodule

// File: tb/tb_crc_16_ccit_checker.sv
// -----------------------------------------------------------------------------
// tb_crc_16_ccit_checker
// Directed stimulus; expected frame results are queued when a frame's eof is
// driven and compared when o_done pulses.
// -----------------------------------------------------------------------------
module tb_crc_16_ccit_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_val;
    logic        i_sof;
    logic        i_eof;
    logic [7:0]  i_data;
    logic        o_busy;
    logic        o_done;
    logic        o_crc_ok;
    logic        o_crc_err;
    logic        o_len_err;
    logic [15:0] o_crc_calc;
    logic [15:0] o_crc_rcv;
    logic [15:0] o_len;

    typedef struct {
        logic        ok;
        logic        err;
        logic        len_err;
        logic        chk_crc;
        logic [15:0] calc;
        logic [15:0] rcv;
        logic [15:0] len;
    } exp_t;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    int         push_cnt = 0;
    int         done_mark;
    logic [7:0] fb[0:15];

    always #5 clk = ~clk;

    crc_16_ccit_checker #(
        .G_CRC_INIT (16'hFFFF),
        .G_LEN_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_val     (i_val),
        .i_sof     (i_sof),
        .i_eof     (i_eof),
        .i_data    (i_data),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_crc_ok  (o_crc_ok),
        .o_crc_err (o_crc_err),
        .o_len_err (o_len_err),
        .o_crc_calc(o_crc_calc),
        .o_crc_rcv (o_crc_rcv),
        .o_len     (o_len)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each o_done pops one expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (o_done === 1'b1) begin
            done_cnt++;
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_done observed=1 expected=0");
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("crc_ok",  {31'd0, o_crc_ok},  {31'd0, e.ok});
                chk("crc_err", {31'd0, o_crc_err}, {31'd0, e.err});
                chk("len_err", {31'd0, o_len_err}, {31'd0, e.len_err});
                chk("len",     {16'd0, o_len},     {16'd0, e.len});
                if (e.chk_crc) begin
                    chk("crc_calc", {16'd0, o_crc_calc}, {16'd0, e.calc});
                    chk("crc_rcv",  {16'd0, o_crc_rcv},  {16'd0, e.rcv});
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_val  = 1'b0;
            i_sof  = 1'b0;
            i_eof  = 1'b0;
            i_data = 8'h00;
        end
    endtask

    task automatic drive(input logic sof, input logic eof, input logic [7:0] d);
        @(negedge clk);
        i_val  = 1'b1;
        i_sof  = sof;
        i_eof  = eof;
        i_data = d;
    endtask

    // Sends fb[0..n-1] as one frame; optional random idle gaps between bytes.
    task automatic send(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                idle(int'($urandom_range(0, 2)));
            end
            drive(k == 0, k == n - 1, fb[k]);
        end
    endtask

    task automatic expect_crc(input logic ok, input logic [15:0] calc,
                              input logic [15:0] rcv, input logic [15:0] len);
        exp_t e;
        e.ok = ok; e.err = ~ok; e.len_err = 1'b0; e.chk_crc = 1'b1;
        e.calc = calc; e.rcv = rcv; e.len = len;
        sb_q.push_back(e);
        push_cnt++;
    endtask

    task automatic expect_len_err();
        exp_t e;
        e.ok = 1'b0; e.err = 1'b0; e.len_err = 1'b1; e.chk_crc = 1'b0;
        e.calc = 16'h0000; e.rcv = 16'h0000; e.len = 16'h0000;
        sb_q.push_back(e);
        push_cnt++;
    endtask

    task automatic load_check_str(input logic [7:0] last);
        for (int k = 0; k < 9; k++) begin
            fb[k] = 8'h31 + 8'(k);
        end
        fb[9]  = 8'h29;
        fb[10] = last;
    endtask

    // Bounded wait for the scoreboard to drain.
    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout observed=%0d expected=0", tag, sb_q.size());
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        i_val  = 1'b0;
        i_sof  = 1'b0;
        i_eof  = 1'b0;
        i_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",    {31'd0, o_busy},    32'd0);
        chk("rst_done",    {31'd0, o_done},    32'd0);
        chk("rst_ok",      {31'd0, o_crc_ok},  32'd0);
        chk("rst_err",     {31'd0, o_crc_err}, 32'd0);
        chk("rst_len_err", {31'd0, o_len_err}, 32'd0);
        chk("rst_calc",    {16'd0, o_crc_calc}, 32'd0);
        chk("rst_rcv",     {16'd0, o_crc_rcv},  32'd0);
        chk("rst_len",     {16'd0, o_len},      32'd0);
        rst_n = 1'b1;
        idle(2);

        // "123456789" + 29B1, gap-free
        load_check_str(8'hB1);
        expect_crc(1'b1, 16'h29B1, 16'h29B1, 16'd9);
        send(11, 1'b0);
        idle(1);
        chk("busy_after_frame", {31'd0, o_busy}, 32'd0);
        drain("good");

        // Corrupted CRC LSB
        load_check_str(8'hB0);
        expect_crc(1'b0, 16'h29B1, 16'h29B0, 16'd9);
        send(11, 1'b0);
        idle(2);
        drain("bad");

        // Minimal valid frame with random gaps; exactly one done
        done_mark = done_cnt;
        fb[0] = 8'h00; fb[1] = 8'hE1; fb[2] = 8'hF0;
        expect_crc(1'b1, 16'hE1F0, 16'hE1F0, 16'd1);
        send(3, 1'b1);
        idle(4);
        drain("gaps");
        chk("gaps_done_once", 32'(done_cnt - done_mark), 32'd1);

        // 2-byte frame and 1-byte sof&eof frame
        fb[0] = 8'hAA; fb[1] = 8'hBB;
        expect_len_err();
        send(2, 1'b0);
        idle(2);
        drain("two_byte");
        expect_len_err();
        drive(1'b1, 1'b1, 8'h55);
        idle(2);
        drain("one_byte");

        // Abandoned frame then restart: single done
        done_mark = done_cnt;
        drive(1'b1, 1'b0, 8'h31);
        drive(1'b0, 1'b0, 8'h32);
        idle(1);
        chk("busy_in_frame", {31'd0, o_busy}, 32'd1);
        load_check_str(8'hB1);
        expect_crc(1'b1, 16'h29B1, 16'h29B1, 16'd9);
        send(11, 1'b0);
        // Back-to-back: next sof right after eof
        expect_crc(1'b1, 16'h29B1, 16'h29B1, 16'd9);
        send(11, 1'b0);
        idle(2);
        drain("restart");
        chk("restart_done_cnt", 32'(done_cnt - done_mark), 32'd2);

        // sof&eof arriving mid-frame drops the old frame, reports length error
        drive(1'b1, 1'b0, 8'h10);
        drive(1'b0, 1'b0, 8'h20);
        expect_len_err();
        drive(1'b1, 1'b1, 8'h30);
        idle(2);
        drain("sof_eof_rx");

        // Restore a known good result, then reset mid-frame
        load_check_str(8'hB1);
        expect_crc(1'b1, 16'h29B1, 16'h29B1, 16'd9);
        send(11, 1'b0);
        idle(2);
        drain("pre_reset");
        done_mark = done_cnt;
        drive(1'b1, 1'b0, 8'h31);
        drive(1'b0, 1'b0, 8'h32);
        drive(1'b0, 1'b0, 8'h33);
        @(negedge clk);
        i_val = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, o_busy},     32'd0);
        chk("mid_rst_ok",   {31'd0, o_crc_ok},   32'd0);
        chk("mid_rst_calc", {16'd0, o_crc_calc}, 32'd0);
        chk("mid_rst_len",  {16'd0, o_len},      32'd0);
        rst_n = 1'b1;
        idle(1);
        // Bytes without sof are ignored after reset
        drive(1'b0, 1'b0, 8'h34);
        drive(1'b0, 1'b1, 8'h35);
        idle(4);
        chk("post_rst_no_done", 32'(done_cnt - done_mark), 32'd0);
        chk("post_rst_busy",    {31'd0, o_busy},    32'd0);
        chk("post_rst_ok",      {31'd0, o_crc_ok},  32'd0);
        chk("done_total",       32'(done_cnt),      32'(push_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
